// File: rtl/nbr_pkg.sv
// Shared types and helpers for the neuron buffer rotator.
// FSM encoding and the role-rotation index function.
package nbr_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } nbr_state_e;

   function automatic int unsigned nbr_next(
      input int unsigned idx,
      input int unsigned nb
   );
      return (idx + 1 >= nb) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/nbr_role_mux.sv
// Combinational bank routing for the read and write roles.
// NBR_POOL_EN adds the pooling mux on the partial-sum operand.
module nbr_role_mux
   import nbr_pkg::*;
#(
   parameter int NB  = 2,
   parameter int WD  = 64,
   parameter int A   = 7,
   parameter int IOW = 19,
   parameter int BW  = 1
) (
   input  logic [BW-1:0]     i_r,
   input  logic [BW-1:0]     i_w,
   input  logic              i_do_pool,
   input  logic              i_commit,
   input  logic [A-1:0]      i_rd_addr,
   input  logic [A-1:0]      i_wr_addr,
   input  logic              i_rd_we,
   input  logic              i_wr_we,
   input  logic [WD-1:0]     i_pool,
   input  logic [IOW-1:0]    i_io_in,
   input  logic [NB*WD-1:0]  i_bank_dout,
   output logic [NB*A-1:0]   o_bank_addr,
   output logic [NB-1:0]     o_bank_we,
   output logic [NB*WD-1:0]  o_bank_din,
   output logic [NB*IOW-1:0] o_bank_io_in,
   output logic [WD-1:0]     o_nbuf,
   output logic [WD-1:0]     o_psum
);

   logic [WD-1:0] w_rd_data;
   logic [WD-1:0] w_wr_data;

   always_comb begin
      o_bank_addr  = '0;
      o_bank_we    = '0;
      o_bank_din   = '0;
      o_bank_io_in = '0;
      w_rd_data    = '0;
      w_wr_data    = '0;
      for (int b = 0; b < NB; b++) begin
         if (BW'(b) == i_r) begin
            o_bank_addr[b*A +: A]      = i_rd_addr;
            o_bank_we[b]               = i_rd_we & ~i_commit;
            o_bank_io_in[b*IOW +: IOW] = i_io_in;
            w_rd_data                  = i_bank_dout[b*WD +: WD];
         end else if (BW'(b) == i_w) begin
            o_bank_addr[b*A +: A]   = i_wr_addr;
            o_bank_we[b]            = i_wr_we & ~i_commit;
            o_bank_din[b*WD +: WD]  = i_pool;
            w_wr_data               = i_bank_dout[b*WD +: WD];
         end
      end
   end

   assign o_nbuf = w_rd_data;

`ifdef NBR_POOL_EN
   assign o_psum = i_do_pool ? w_rd_data : w_wr_data;
`else
   logic w_unused_pool;
   assign w_unused_pool = i_do_pool;
   assign o_psum        = w_wr_data;
`endif

endmodule

// File: rtl/neuron_buffer_rotator.sv
// Role controller for NB neuron buffer banks with drained swap.
// Define NBR_POOL_EN to honour doPooling on the partial-sum path.
module neuron_buffer_rotator
   import nbr_pkg::*;
#(
   parameter int NB           = 2,
   parameter int DEPTH        = 2,
   parameter int D            = 1 << DEPTH,
   parameter int W            = 16,
   parameter int A            = 7,
   parameter int DRAIN_CYCLES = 3,
   parameter int BW           = (NB > 2) ? 2 : 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          swapReq,
   output logic                          swapAck,
   output logic                          busy,
   input  logic                          doPooling,
   input  logic [A-1:0]                  readBuffAddress,
   input  logic [A-1:0]                  writeBuffAddress,
   input  logic                          nRWrite,
   input  logic                          nWWrite,
   output logic [NB*A-1:0]               bankAddress,
   output logic [NB-1:0]                 bankWrite,
   input  logic [NB*W*D-1:0]             bankDataOut,
   output logic [NB*W*D-1:0]             bankDataIn,
   input  logic [W*D-1:0]                fromPoolUnitOut,
   output logic [W*D-1:0]                toConvUnitNBuffIn,
   output logic [W*D-1:0]                toConvUnitPartialSum,
   input  logic [W+DEPTH:0]              ioIn,
   output logic [W-1:0]                  ioOut,
   output logic [NB*(W+DEPTH+1)-1:0]     bankIoIn,
   input  logic [NB*W-1:0]               bankIoOut,
   output logic [BW-1:0]                 readSel,
   output logic [BW-1:0]                 writeSel,
   output logic [7:0]                    layerCount
);

   localparam logic [3:0] DC = 4'(DRAIN_CYCLES);

   nbr_state_e    r_state, w_state_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [BW-1:0] r_sel;
   logic [BW-1:0] w_wsel;
   logic [7:0]    r_layer;
   logic [W-1:0]  r_io_out;
   logic [W-1:0]  w_io_sel;
   logic          w_commit;

   assign w_wsel   = BW'(nbr_next(32'(r_sel), NB));
   assign w_commit = (r_state == COMMIT);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         RUN: begin
            if (swapReq) begin
               w_state_nxt = DRAIN;
               w_cnt_nxt   = DC;
            end
         end
         // A pool write restarts the flush window.
         DRAIN: begin
            if (nWWrite)
               w_cnt_nxt = DC;
            else if (r_cnt == 4'd0)
               w_state_nxt = COMMIT;
            else
               w_cnt_nxt = r_cnt - 4'd1;
         end
         COMMIT:  w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   always_comb begin
      w_io_sel = '0;
      for (int b = 0; b < NB; b++)
         if (BW'(b) == r_sel)
            w_io_sel = bankIoOut[b*W +: W];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= RUN;
         r_cnt    <= '0;
         r_sel    <= '0;
         r_layer  <= '0;
         r_io_out <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_io_out <= w_io_sel;
         if (w_commit) begin
            r_sel   <= w_wsel;
            r_layer <= r_layer + 8'd1;
         end
      end
   end

   assign swapAck    = w_commit;
   assign busy       = (r_state != RUN);
   assign readSel    = r_sel;
   assign writeSel   = w_wsel;
   assign layerCount = r_layer;
   assign ioOut      = r_io_out;

   nbr_role_mux #(
      .NB  (NB),
      .WD  (W*D),
      .A   (A),
      .IOW (W+DEPTH+1),
      .BW  (BW)
   ) u_mux (
      .i_r          (r_sel),
      .i_w          (w_wsel),
      .i_do_pool    (doPooling),
      .i_commit     (w_commit),
      .i_rd_addr    (readBuffAddress),
      .i_wr_addr    (writeBuffAddress),
      .i_rd_we      (nRWrite),
      .i_wr_we      (nWWrite),
      .i_pool       (fromPoolUnitOut),
      .i_io_in      (ioIn),
      .i_bank_dout  (bankDataOut),
      .o_bank_addr  (bankAddress),
      .o_bank_we    (bankWrite),
      .o_bank_din   (bankDataIn),
      .o_bank_io_in (bankIoIn),
      .o_nbuf       (toConvUnitNBuffIn),
      .o_psum       (toConvUnitPartialSum)
   );

endmodule

// File: tb/tb_neuron_buffer_rotator.sv
// Directed bench for neuron_buffer_rotator, NB=2 and NB=3 instances.
// Expected partial-sum value follows NBR_POOL_EN.
module tb_neuron_buffer_rotator;

   localparam int W   = 16;
   localparam int DP  = 2;
   localparam int WD  = 64;
   localparam int A   = 7;
   localparam int IOW = 19;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic           swapReq, swapReq3;
   logic           doPooling;
   logic [A-1:0]   rdAddr, wrAddr;
   logic           nRWrite, nWWrite, nWWrite3;
   logic [WD-1:0]  pool;
   logic [IOW-1:0] ioIn;

   logic           ack2, busy2;
   logic [2*A-1:0] addr2;
   logic [1:0]     we2;
   logic [2*WD-1:0] dout2, din2;
   logic [WD-1:0]  nbuf2, psum2;
   logic [W-1:0]   ioOut2;
   logic [2*IOW-1:0] ioIn2;
   logic [2*W-1:0] ioOutB2;
   logic [0:0]     rs2, ws2;
   logic [7:0]     lc2;

   logic           ack3, busy3;
   logic [3*A-1:0] addr3;
   logic [2:0]     we3;
   logic [3*WD-1:0] dout3, din3;
   logic [WD-1:0]  nbuf3, psum3;
   logic [W-1:0]   ioOut3;
   logic [3*IOW-1:0] ioIn3;
   logic [3*W-1:0] ioOutB3;
   logic [1:0]     rs3, ws3;
   logic [7:0]     lc3;

   int checks = 0;
   int errors = 0;

   neuron_buffer_rotator #(.NB(2), .DEPTH(DP), .W(W), .A(A),
      .DRAIN_CYCLES(3)) dut2 (
      .clk(clk), .rstn(rstn), .swapReq(swapReq), .swapAck(ack2),
      .busy(busy2), .doPooling(doPooling),
      .readBuffAddress(rdAddr), .writeBuffAddress(wrAddr),
      .nRWrite(nRWrite), .nWWrite(nWWrite),
      .bankAddress(addr2), .bankWrite(we2),
      .bankDataOut(dout2), .bankDataIn(din2),
      .fromPoolUnitOut(pool), .toConvUnitNBuffIn(nbuf2),
      .toConvUnitPartialSum(psum2), .ioIn(ioIn), .ioOut(ioOut2),
      .bankIoIn(ioIn2), .bankIoOut(ioOutB2),
      .readSel(rs2), .writeSel(ws2), .layerCount(lc2));

   neuron_buffer_rotator #(.NB(3), .DEPTH(DP), .W(W), .A(A),
      .DRAIN_CYCLES(3)) dut3 (
      .clk(clk), .rstn(rstn), .swapReq(swapReq3), .swapAck(ack3),
      .busy(busy3), .doPooling(doPooling),
      .readBuffAddress(rdAddr), .writeBuffAddress(wrAddr),
      .nRWrite(nRWrite), .nWWrite(nWWrite3),
      .bankAddress(addr3), .bankWrite(we3),
      .bankDataOut(dout3), .bankDataIn(din3),
      .fromPoolUnitOut(pool), .toConvUnitNBuffIn(nbuf3),
      .toConvUnitPartialSum(psum3), .ioIn(ioIn), .ioOut(ioOut3),
      .bankIoIn(ioIn3), .bankIoOut(ioOutB3),
      .readSel(rs3), .writeSel(ws3), .layerCount(lc3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [2:0] exp_we3 [3] = '{3'b011, 3'b110, 3'b101};
   logic [1:0] exp_r3  [3] = '{2'd1, 2'd2, 2'd0};
   logic [1:0] exp_w3  [3] = '{2'd2, 2'd0, 2'd1};
   int         n;

   initial begin
      rstn = 1'b0; swapReq = 0; swapReq3 = 0; doPooling = 0;
      rdAddr = 0; wrAddr = 0; nRWrite = 0; nWWrite = 0; nWWrite3 = 0;
      pool = 64'h1234_5678_9abc_def0;
      ioIn = 19'h54321;
      dout2 = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      dout3 = {64'hCCCC_CCCC_CCCC_CCCC, dout2};
      ioOutB2 = {16'h2222, 16'h1111};
      ioOutB3 = {16'h3333, ioOutB2};
      #12;
      chk("rst_readSel", rs2, 0);
      chk("rst_writeSel", ws2, 1);
      chk("rst_ioOut", ioOut2, 0);
      chk("rst_ack", ack2, 0);
      chk("rst_busy", busy2, 0);
      chk("rst_layer", lc2, 0);
      rstn = 1'b1;
      rdAddr = 7'd5; wrAddr = 7'd9;
      tick();
      chk("route_addr", addr2, {7'd9, 7'd5});
      chk("ioOut_bank0", ioOut2, 16'h1111);
      chk("dataIn_w", din2, {pool, 64'h0});
      chk("ioIn_r", ioIn2, {19'h0, 19'h54321});
      chk("nbuf_r0", nbuf2, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("psum_nopool", psum2, 64'hBBBB_BBBB_BBBB_BBBB);
      doPooling = 1; #1;
`ifdef NBR_POOL_EN
      chk("psum_pool", psum2, 64'hAAAA_AAAA_AAAA_AAAA);
`else
      chk("psum_pool", psum2, 64'hBBBB_BBBB_BBBB_BBBB);
`endif
      doPooling = 0;
      nRWrite = 1; #1;
      chk("we_run", we2, 2'b01);

      // swap with no writes
      swapReq = 1;
      tick();
      swapReq = 0;
      chk("drain_busy", busy2, 1);
      chk("drain_ack0", ack2, 0);
      tick(); tick(); tick();
      chk("drain_ack3", ack2, 0);
      tick();
      chk("commit_ack", ack2, 1);
      chk("commit_we0", we2, 2'b00);
      chk("commit_readSel", rs2, 0);
      tick();
      nRWrite = 0;
      chk("post_ack", ack2, 0);
      chk("post_busy", busy2, 0);
      chk("post_readSel", rs2, 1);
      chk("post_writeSel", ws2, 0);
      chk("post_layer", lc2, 1);
      chk("io_pre_rot", ioOut2, 16'h1111);
      chk("post_addr", addr2, {7'd5, 7'd9});
      tick();
      chk("io_post_rot", ioOut2, 16'h2222);

      // swap with two pool writes during drain
      swapReq = 1;
      tick();
      swapReq = 0;
      nWWrite = 1; #1;
      chk("drain_we_old", we2, 2'b01);
      chk("drain_addr_old", addr2, {7'd5, 7'd9});
      tick(); tick();
      nWWrite = 0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack2 === 1'b1) begin n = i; break; end
      end
      chk("drain_reload_lat", n, 4);
      tick();
      chk("swap2_readSel", rs2, 0);
      chk("swap2_layer", lc2, 2);

      // second request while draining is ignored
      swapReq = 1;
      tick(); tick();
      swapReq = 0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack2 === 1'b1) n++;
      end
      chk("one_ack", n, 1);
      chk("swap3_readSel", rs2, 1);
      chk("swap3_layer", lc2, 3);

      // NB=3 rotation
      chk("nb3_r0", rs3, 0);
      chk("nb3_w0", ws3, 1);
      for (int k = 0; k < 3; k++) begin
         nWWrite3 = 1; nRWrite = 1; #1;
         chk("nb3_we_run", we3, exp_we3[k]);
         nWWrite3 = 0; nRWrite = 0;
         swapReq3 = 1;
         tick();
         swapReq3 = 0;
         tick(); tick(); tick(); tick();
         chk("nb3_ack", ack3, 1);
         nWWrite3 = 1; nRWrite = 1; #1;
         chk("nb3_commit_we", we3, 3'b000);
         tick();
         nWWrite3 = 0; nRWrite = 0;
         chk("nb3_readSel", rs3, exp_r3[k]);
         chk("nb3_writeSel", ws3, exp_w3[k]);
      end
      chk("nb3_layer", lc3, 3);

      // reset in the middle of a drain
      swapReq = 1;
      tick();
      swapReq = 0;
      tick();
      chk("pre_rst_busy", busy2, 1);
      rstn = 1'b0; #1;
      chk("mid_rst_busy", busy2, 0);
      chk("mid_rst_readSel", rs2, 0);
      chk("mid_rst_layer", lc2, 0);
      chk("mid_rst_ioOut", ioOut2, 0);
      #3;
      rstn = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack2 === 1'b1) n++;
      end
      chk("no_ack_after_rst", n, 0);
      chk("idle_busy", busy2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_buffer_rotator.md
# neuron_buffer_rotator

Registered role controller and data router for NB neuron buffer banks, where NB ranges from 2 (ping-pong) to 4. One bank is the read bank: it feeds the conv unit and the host IO port. The next bank in rotation is the write bank: it receives pool-unit output and supplies partial sums. Roles advance only through a swap handshake that first drains in-flight pool writes. The block sits between the conv/pool datapath and the bank array.

## Interface
- NB, 2: number of banks, 2..4.
- DEPTH, 2: log2 of neurons per bank word.
- D, 1<<DEPTH: neurons per word.
- W, 16: neuron width.
- A, 7: bank address width.
- DRAIN_CYCLES, 3: pool-pipeline flush length after the last write, 1..15.
- BW, (NB>2)?2:1: bank-select width (derived).
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- swapReq  in  1  single-cycle request to rotate roles after a layer.
- swapAck  out  1  one-cycle pulse in the commit cycle.
- busy  out  1  high while draining or committing.
- doPooling  in  1  pooling mode select.
- readBuffAddress, writeBuffAddress  in  A  read-role and write-role addresses.
- nRWrite, nWWrite  in  1  read-role and write-role write enables.
- bankAddress  out  NB*A  per-bank address.
- bankWrite  out  NB  per-bank write enable.
- bankDataOut  in  NB*W*D  per-bank read data.
- bankDataIn  out  NB*W*D  per-bank write data.
- fromPoolUnitOut  in  W*D  pool result.
- toConvUnitNBuffIn, toConvUnitPartialSum  out  W*D  conv operands.
- ioIn  in  W+DEPTH+1  host IO word.
- ioOut  out  W  registered host read data.
- bankIoIn  out  NB*(W+DEPTH+1)  per-bank IO in.
- bankIoOut  in  NB*W  per-bank IO out.
- readSel, writeSel  out  BW  current role indices.
- layerCount  out  8  completed swaps.

## Operation
- State register r (read bank index); w = (r+1) mod NB. readSel=r, writeSel=w.
- Routing, combinational from r and w:
  - Bank r gets readBuffAddress and nRWrite; bank w gets writeBuffAddress and nWWrite.
  - Other banks get address 0 and write 0.
  - bankDataIn[w]=fromPoolUnitOut; all other banks 0.
  - bankIoIn[r]=ioIn; all other banks 0.
  - toConvUnitNBuffIn = bankDataOut[r].
  - toConvUnitPartialSum = bankDataOut[w]. When doPooling=1 it is bankDataOut[r].
- FSM RUN/DRAIN/COMMIT:
  - RUN, swapReq=1: go to DRAIN and load drain counter with DRAIN_CYCLES.
  - DRAIN: any cycle with nWWrite=1 reloads the counter; otherwise it decrements. Counter at 0 (with no write this cycle) goes to COMMIT.
  - COMMIT: all bankWrite forced 0, swapAck=1, r advances, layerCount increments (wraps 255 to 0), then return to RUN.
- swapReq outside RUN is ignored: exactly one swapAck per accepted request.
- Routing stays live in DRAIN using the old roles, so pool writes land in the old write bank.
- busy = (state != RUN).
- ioOut <= bankIoOut[r] each cycle (one-cycle latency, uses the pre-rotation r in the commit cycle).
- Reset, asynchronous and also mid-drain: state RUN, r=0, counter 0, layerCount 0, swapAck 0, ioOut 0.
  - Combinational outputs then reflect r=0, w=1.

## Timing
- Address, write, data and IO routing: zero-cycle, combinational from registered r.
- Minimum request-to-swapAck with no writes: DRAIN_CYCLES+1 cycles. The request edge enters DRAIN; DRAIN_CYCLES decrements follow; commit happens on the next edge.
- Roles (readSel/writeSel) change on the clock edge that ends the COMMIT cycle; swapAck is low again in that same cycle.
- ioOut: one-cycle latency from bankIoOut.

## Configuration
- NBR_POOL_EN defined: doPooling is honoured as described above.
- NBR_POOL_EN undefined: doPooling is ignored, toConvUnitPartialSum is always bankDataOut[w], and the pooling mux is not synthesised.

## Structure
- Package nbr_pkg holds:
  - FSM state encoding (RUN=0, DRAIN=1, COMMIT=2).
  - The next-index function (r+1) mod NB.
- Sub-module nbr_role_mux holds all combinational routing, given r, w, doPooling and the commit-cycle write gate.
- The top level holds the FSM, drain counter, role register, layerCount and the ioOut register.

## Test plan
- Reset then idle, NB=2: readSel=0, writeSel=1, ioOut=0; readBuffAddress=5 drives bankAddress[0]=5; writeBuffAddress=9 drives bankAddress[1]=9.
- swapReq pulse, no writes, DRAIN_CYCLES=3: swapAck rises 4 cycles later for one cycle; readSel then =1; layerCount=1.
- nWWrite high 2 cycles after swapReq: counter reloads and swapAck is delayed by 2 cycles; those writes go to the old write bank.
- NB=3, three swaps: readSel sequence 0,1,2,0; writeSel 1,2,0,1; in each COMMIT cycle bankWrite=0 even with nWWrite=1.
- doPooling=1 with NBR_POOL_EN, r=0: both conv outputs equal bankDataOut[0]. Without the macro, toConvUnitPartialSum equals bankDataOut[1].
- rstn pulsed low in DRAIN: swapAck never fires, busy=0 immediately, readSel=0, layerCount=0.
